// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, opcodes and the memory-stage state type.
package cpu_pkg;

   localparam int DATA_W    = 16;
   localparam int REG_IDX_W = 5;
   localparam int CTRL_W    = 5;
   localparam int OP_W      = 4;

   localparam logic [OP_W-1:0] OP_NOP   = 4'h0;
   localparam logic [OP_W-1:0] OP_AND   = 4'h1;
   localparam logic [OP_W-1:0] OP_ADD   = 4'h2;
   localparam logic [OP_W-1:0] OP_ADDI  = 4'h3;
   localparam logic [OP_W-1:0] OP_SUB   = 4'h4;
   localparam logic [OP_W-1:0] OP_OR    = 4'h5;
   localparam logic [OP_W-1:0] OP_XOR   = 4'h6;
   localparam logic [OP_W-1:0] OP_SLL   = 4'h7;
   localparam logic [OP_W-1:0] OP_SRL   = 4'h8;
   localparam logic [OP_W-1:0] OP_CMP   = 4'h9;
   localparam logic [OP_W-1:0] OP_BEQ   = 4'hA;
   localparam logic [OP_W-1:0] OP_JMP   = 4'hB;
   localparam logic [OP_W-1:0] OP_LOAD  = 4'hC;
   localparam logic [OP_W-1:0] OP_LUI   = 4'hD;
   localparam logic [OP_W-1:0] OP_STORE = 4'hE;
   localparam logic [OP_W-1:0] OP_MOV   = 4'hF;

   typedef enum logic {
      IDLE,
      ACCESS
   } mem_state_e;

   function automatic logic is_mem_op(input logic [OP_W-1:0] op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Access-cycle counter: cleared on access entry, flags expiry at the limit.
module mem_watchdog #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] count_q, count_d;
   logic             at_limit;

   assign at_limit  = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign expired_o = en_i && at_limit;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (en_i && !at_limit) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: LOAD/STORE handshake with data memory, others pass.
// Define MEM_TIMEOUT_EN to bound each access with the mem_watchdog counter.
module memory_stage #(
   parameter int ADDR_W         = 14,
   parameter int DATA_W         = cpu_pkg::DATA_W,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           ex_valid,
   input  logic [cpu_pkg::CTRL_W-1:0]     control_in,
   input  logic [cpu_pkg::REG_IDX_W-1:0]  dest_index_in,
   input  logic [DATA_W-1:0]              result_in,
   input  logic [DATA_W-1:0]              store_data,
   input  logic                           dest_write_en_in,
   output logic                           stall,
   output logic                           mem_req,
   output logic                           mem_we,
   output logic [ADDR_W-1:0]              mem_addr,
   output logic [DATA_W-1:0]              mem_wdata,
   input  logic                           mem_ready,
   input  logic [DATA_W-1:0]              mem_rdata,
   output logic                           wb_valid,
   output logic [cpu_pkg::CTRL_W-1:0]     wb_control,
   output logic [cpu_pkg::REG_IDX_W-1:0]  wb_dest_index,
   output logic [DATA_W-1:0]              wb_data,
   output logic                           wb_write_en,
   output logic                           mem_error
);

   import cpu_pkg::*;

   mem_state_e             state_q, state_d;
   logic                   mem_req_q, mem_req_d;
   logic                   mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
   logic [CTRL_W-1:0]      ctrl_q, ctrl_d;
   logic [REG_IDX_W-1:0]   dest_q, dest_d;
   logic                   wb_valid_q, wb_valid_d;
   logic [CTRL_W-1:0]      wb_ctrl_q, wb_ctrl_d;
   logic [REG_IDX_W-1:0]   wb_dest_q, wb_dest_d;
   logic [DATA_W-1:0]      wb_data_q, wb_data_d;
   logic                   wb_we_q, wb_we_d;
   logic                   mem_error_q, mem_error_d;
   logic                   stall_c;
   logic                   accept;
   logic                   timeout;
   logic                   in_access;

   assign in_access = (state_q == ACCESS);
   assign accept    = (state_q == IDLE) && ex_valid
                      && is_mem_op(control_in[OP_W-1:0]);

`ifdef MEM_TIMEOUT_EN
   mem_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_mem_watchdog (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (accept),
      .en_i     (in_access),
      .expired_o(timeout)
   );
`else
   assign timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      ctrl_d      = ctrl_q;
      dest_d      = dest_q;
      wb_valid_d  = 1'b0;
      wb_ctrl_d   = wb_ctrl_q;
      wb_dest_d   = wb_dest_q;
      wb_data_d   = wb_data_q;
      wb_we_d     = 1'b0;
      mem_error_d = mem_error_q;
      stall_c     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               stall_c     = 1'b1;
               state_d     = ACCESS;
               mem_req_d   = 1'b1;
               mem_we_d    = (control_in[OP_W-1:0] == OP_STORE);
               mem_addr_d  = result_in[ADDR_W-1:0];
               mem_wdata_d = store_data;
               ctrl_d      = control_in;
               dest_d      = dest_index_in;
            end else if (ex_valid) begin
               wb_valid_d = 1'b1;
               wb_ctrl_d  = control_in;
               wb_dest_d  = dest_index_in;
               wb_data_d  = result_in;
               wb_we_d    = dest_write_en_in;
            end
         end
         ACCESS: begin
            stall_c = ~mem_ready & ~timeout;
            if (mem_ready || timeout) begin
               state_d     = IDLE;
               mem_req_d   = 1'b0;
               mem_we_d    = 1'b0;
               mem_addr_d  = '0;
               mem_wdata_d = '0;
               wb_valid_d  = 1'b1;
               wb_ctrl_d   = ctrl_q;
               wb_dest_d   = dest_q;
            end
            // A ready arriving on the timeout cycle still completes cleanly.
            if (mem_ready) begin
               wb_data_d = mem_we_q ? DATA_W'(mem_addr_q) : mem_rdata;
               wb_we_d   = ~mem_we_q;
            end else if (timeout) begin
               wb_data_d   = '0;
               mem_error_d = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         ctrl_q      <= '0;
         dest_q      <= '0;
         wb_valid_q  <= 1'b0;
         wb_ctrl_q   <= '0;
         wb_dest_q   <= '0;
         wb_data_q   <= '0;
         wb_we_q     <= 1'b0;
         mem_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         ctrl_q      <= ctrl_d;
         dest_q      <= dest_d;
         wb_valid_q  <= wb_valid_d;
         wb_ctrl_q   <= wb_ctrl_d;
         wb_dest_q   <= wb_dest_d;
         wb_data_q   <= wb_data_d;
         wb_we_q     <= wb_we_d;
         mem_error_q <= mem_error_d;
      end
   end

   assign stall         = stall_c;
   assign mem_req       = mem_req_q;
   assign mem_we        = mem_we_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign wb_valid      = wb_valid_q;
   assign wb_control    = wb_ctrl_q;
   assign wb_dest_index = wb_dest_q;
   assign wb_data       = wb_data_q;
   assign wb_write_en   = wb_we_q;
   assign mem_error     = mem_error_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with a retirement-queue reference model.
module tb_memory_stage;
   import cpu_pkg::*;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid;
   logic [4:0]  control_in;
   logic [4:0]  dest_index_in;
   logic [15:0] result_in;
   logic [15:0] store_data;
   logic        dest_write_en_in;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [13:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_ready;
   logic [15:0] mem_rdata;
   logic        wb_valid;
   logic [4:0]  wb_control;
   logic [4:0]  wb_dest_index;
   logic [15:0] wb_data;
   logic        wb_write_en;
   logic        mem_error;

   memory_stage #(
      .ADDR_W(14),
      .DATA_W(16),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .ex_valid(ex_valid),
      .control_in(control_in),
      .dest_index_in(dest_index_in),
      .result_in(result_in),
      .store_data(store_data),
      .dest_write_en_in(dest_write_en_in),
      .stall(stall),
      .mem_req(mem_req),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_ready(mem_ready),
      .mem_rdata(mem_rdata),
      .wb_valid(wb_valid),
      .wb_control(wb_control),
      .wb_dest_index(wb_dest_index),
      .wb_data(wb_data),
      .wb_write_en(wb_write_en),
      .mem_error(mem_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  ctrl;
      logic [4:0]  dest;
      logic [15:0] data;
      logic        we;
      bit          chk_data;
   } wb_t;

   wb_t         exp_q[$];
   wb_t         e;
   logic [13:0] exp_addr = '0;
   logic        exp_we = 1'b0;
   logic [15:0] exp_wdata = '0;

   int          checks = 0;
   int          failures = 0;
   time         last_wb_t = 0;
   time         prev_wb_t = 0;
   time         t_done = 0;
   logic [15:0] last_wb_data = '0;
   int          req_starts = 0;
   int          req_cycles = 0;
   logic        req_prev = 1'b0;

   int          resp_delay = 0;
   logic [15:0] resp_data = '0;
   int          resp_cnt = 0;
   logic        resp_ready = 1'b0;
   logic        man_ready = 1'b0;

   assign mem_ready = resp_ready | man_ready;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Memory model: answers the n-th cycle of an open request.
   always @(posedge clk) begin
      #1;
      if (mem_req) begin
         resp_ready = (resp_cnt == resp_delay);
         mem_rdata  = resp_ready ? resp_data : 16'hDEAD;
         resp_cnt++;
      end else begin
         resp_ready = 1'b0;
         resp_cnt   = 0;
         mem_rdata  = 16'hBEEF;
      end
   end

   // Compare process: every retirement must match the queue head in order.
   always @(negedge clk) begin
      if (!reset) begin
         if (wb_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_wb actual=1 required=0");
            end else begin
               e = exp_q.pop_front();
               chk("wb_control", wb_control, e.ctrl);
               chk("wb_dest", wb_dest_index, e.dest);
               chk("wb_write_en", wb_write_en, e.we);
               if (e.chk_data) chk("wb_data", wb_data, e.data);
            end
            prev_wb_t    = last_wb_t;
            last_wb_t    = $time;
            last_wb_data = wb_data;
         end else begin
            chk("wb_we_idle", wb_write_en, 0);
         end
         if (mem_req) begin
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_we", mem_we, exp_we);
            if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
            req_cycles++;
         end
`ifndef MEM_TIMEOUT_EN
         chk("mem_error_tied", mem_error, 0);
`endif
      end
      if (mem_req && !req_prev) req_starts++;
      req_prev = mem_req;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_wb(input logic [4:0] c, input logic [4:0] d,
                            input logic [15:0] v, input logic w,
                            input bit cd);
      wb_t x;
      x.ctrl = c;
      x.dest = d;
      x.data = v;
      x.we = w;
      x.chk_data = cd;
      exp_q.push_back(x);
   endtask

   task automatic issue(input logic [4:0] c, input logic [15:0] r,
                        input logic [15:0] sd, input logic [4:0] d,
                        input logic w, output int stalls);
      int   n;
      logic s;
      n = 0;
      stalls = 0;
      ex_valid = 1'b1;
      control_in = c;
      result_in = r;
      store_data = sd;
      dest_index_in = d;
      dest_write_en_in = w;
      do begin
         @(negedge clk);
         s = stall;
         if (s) stalls++;
         else t_done = $time;
         n++;
         step();
      end while (s && n < 64);
      if (s) begin
         checks++;
         failures++;
         $display("FAIL stall_bound actual=%0d required=<64", n);
      end
      ex_valid = 1'b0;
   endtask

   task automatic drain();
      int i;
      for (i = 0; i < 40; i++) begin
         if (exp_q.size() == 0) break;
         step();
      end
      chk("drain", exp_q.size(), 0);
   endtask

   int st;

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      ex_valid = 1'b0;
      control_in = '0;
      dest_index_in = '0;
      result_in = '0;
      store_data = '0;
      dest_write_en_in = 1'b0;
      step();
      step();
      chk("rst_stall", stall, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_wb_ctrl", wb_control, 0);
      chk("rst_wb_dest", wb_dest_index, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_wb_we", wb_write_en, 0);
      chk("rst_mem_error", mem_error, 0);
      reset = 1'b0;
      step();

      // ADD passes straight through
      expect_wb(5'b00010, 5'd2, 16'd15, 1'b1, 1'b1);
      issue(5'b00010, 16'd15, 16'h0, 5'd2, 1'b1, st);
      chk("add_stall", st, 0);
      drain();
      chk("add_data_lit", last_wb_data, 16'd15);
      chk("add_latency", 32'(last_wb_t - t_done), 10);

      // LOAD, ready on the fourth access cycle
      exp_addr = 14'h0008;
      exp_we = 1'b0;
      resp_delay = 3;
      resp_data = 16'h00AB;
      req_cycles = 0;
      expect_wb(5'b01100, 5'd4, 16'h00AB, 1'b1, 1'b1);
      issue(5'b01100, 16'h0008, 16'h1234, 5'd4, 1'b0, st);
      chk("load_stall_cycles", st, 4);
      drain();
      chk("load_data_lit", last_wb_data, 16'h00AB);
      chk("load_latency", 32'(last_wb_t - t_done), 10);
      chk("load_req_cycles", req_cycles, 4);

      // STORE with immediate ready
      exp_addr = 14'd16;
      exp_we = 1'b1;
      exp_wdata = 16'd31;
      resp_delay = 0;
      req_cycles = 0;
      expect_wb(5'b01110, 5'd3, 16'h0010, 1'b0, 1'b1);
      issue(5'b01110, 16'd16, 16'd31, 5'd3, 1'b1, st);
      chk("store_stall", st, 1);
      drain();
      chk("store_req_cycles", req_cycles, 1);

      // STORE with upper address bits set
      exp_addr = 14'h0005;
      exp_we = 1'b1;
      exp_wdata = 16'h5A5A;
      resp_delay = 1;
      expect_wb(5'b01110, 5'd10, 16'h0005, 1'b0, 1'b1);
      issue(5'b01110, 16'hC005, 16'h5A5A, 5'd10, 1'b0, st);
      chk("store_hi_stall", st, 2);
      drain();
      chk("store_hi_data_lit", last_wb_data, 16'h0005);

      // LOAD then ADDI back-to-back
      exp_addr = 14'h0021;
      exp_we = 1'b0;
      resp_delay = 0;
      resp_data = 16'h0077;
      req_starts = 0;
      expect_wb(5'b01100, 5'd7, 16'h0077, 1'b1, 1'b1);
      issue(5'b01100, 16'h0021, 16'h0, 5'd7, 1'b1, st);
      chk("b2b_load_stall", st, 1);
      expect_wb(5'b00011, 5'd8, 16'd17, 1'b1, 1'b1);
      issue(5'b00011, 16'd17, 16'h0, 5'd8, 1'b1, st);
      chk("b2b_addi_stall", st, 0);
      drain();
      chk("b2b_gap", 32'(last_wb_t - prev_wb_t), 10);
      chk("b2b_no_reissue", req_starts, 1);

      // ALU op with write enable low
      expect_wb(5'b00100, 5'd9, 16'hFFFF, 1'b0, 1'b1);
      issue(5'b00100, 16'hFFFF, 16'h0, 5'd9, 1'b0, st);
      drain();

      // reset while in ACCESS, then a stray ready
      exp_addr = 14'h0020;
      exp_we = 1'b0;
      resp_delay = 1000;
      ex_valid = 1'b1;
      control_in = 5'b01100;
      result_in = 16'h0020;
      dest_index_in = 5'd5;
      dest_write_en_in = 1'b1;
      step();
      ex_valid = 1'b0;
      chk("abort_req_before", mem_req, 1);
      reset = 1'b1;
      step();
      chk("abort_req_after", mem_req, 0);
      chk("abort_wb_valid", wb_valid, 0);
      reset = 1'b0;
      man_ready = 1'b1;
      step();
      man_ready = 1'b0;
      step();
      step();
      chk("abort_req_idle", mem_req, 0);
      chk("abort_stall_idle", stall, 0);
      expect_wb(5'b01111, 5'd1, 16'h4242, 1'b1, 1'b1);
      issue(5'b01111, 16'h4242, 16'h0, 5'd1, 1'b1, st);
      chk("abort_then_alu_stall", st, 0);
      drain();

`ifdef MEM_TIMEOUT_EN
      // no ready at all: watchdog retires the LOAD
      exp_addr = 14'h0003;
      exp_we = 1'b0;
      resp_delay = 1000;
      req_cycles = 0;
      expect_wb(5'b01100, 5'd6, 16'h0, 1'b0, 1'b0);
      issue(5'b01100, 16'h0003, 16'h0, 5'd6, 1'b1, st);
      chk("to_stall_cycles", st, TO);
      drain();
      chk("to_req_cycles", req_cycles, TO);
      chk("to_mem_error", mem_error, 1);
      step();
      step();
      step();
      chk("to_mem_error_sticky", mem_error, 1);
      reset = 1'b1;
      step();
      chk("to_mem_error_cleared", mem_error, 0);
      reset = 1'b0;
      step();
`else
      // long wait: no timeout in this build
      exp_addr = 14'h0003;
      exp_we = 1'b0;
      resp_delay = 20;
      resp_data = 16'hCAFE;
      expect_wb(5'b01100, 5'd6, 16'hCAFE, 1'b1, 1'b1);
      issue(5'b01100, 16'h0003, 16'h0, 5'd6, 1'b0, st);
      chk("long_stall_cycles", st, 21);
      drain();
      chk("long_mem_error", mem_error, 0);
`endif

      step();
      chk("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage that sits directly after Execute; it consumes Execute's result, destination and control bundle.
- LOAD and STORE run a req/ready handshake with data memory and stall Execute until the access completes.
- Every other opcode passes through in one registered cycle.
- Output is the writeback bundle (dest index, data, write enable) for the register file.

Parameters:
- ADDR_W, 14, data-memory address width; taken from the low bits of result_in.
- DATA_W, 16, datapath width.
- TIMEOUT_CYCLES, 16, ACCESS-cycle limit; used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  input  1  pipeline clock
- reset  input  1  synchronous, active-high reset
- ex_valid  input  1  Execute bundle valid
- control_in  input  5  Execute control; opcode in [3:0]
- dest_index_in  input  5  destination register index
- result_in  input  DATA_W  ALU result; memory address for LOAD/STORE
- store_data  input  DATA_W  register value written by STORE
- dest_write_en_in  input  1  Execute's register write enable
- stall  output  1  Execute must hold its bundle
- mem_req  output  1  memory request
- mem_we  output  1  1=write, 0=read
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  write data
- mem_ready  input  1  memory completes the current request
- mem_rdata  input  DATA_W  read data, valid while mem_ready=1
- wb_valid  output  1  writeback bundle valid (one-cycle pulse per instruction)
- wb_control  output  5  control of the retiring instruction
- wb_dest_index  output  5  writeback register index
- wb_data  output  DATA_W  writeback data
- wb_write_en  output  1  register-file write enable
- mem_error  output  1  sticky timeout flag

Behaviour:
- Reset values:
  - state=IDLE.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, wb_*, mem_error.
  - Reset mid-ACCESS: abort; mem_req drops at the reset edge; any later mem_ready is ignored; no wb_valid for the aborted instruction.
- FSM has two states: IDLE and ACCESS.
- Non-memory opcodes (state IDLE, ex_valid=1, opcode not LOAD 4'b1100 or STORE 4'b1110):
  - stall=0.
  - Next edge: wb_valid=1, wb_data=result_in, wb_dest_index=dest_index_in, wb_control=control_in, wb_write_en=dest_write_en_in.
  - Latency is 1 cycle; one instruction accepted per cycle.
- ex_valid=0 in IDLE: wb_valid=0 next cycle; wb_write_en forced 0.
- Memory op accept (IDLE, ex_valid=1, LOAD or STORE):
  - stall=1 combinationally.
  - Bundle is latched; mem_addr=result_in[ADDR_W-1:0]; upper result bits are ignored.
  - mem_we=1 for STORE; mem_wdata=store_data.
  - Next edge: mem_req=1, state goes to ACCESS.
- ACCESS:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - stall = ~mem_ready. Execute therefore advances exactly once, on the completion cycle.
  - Execute inputs are ignored while in ACCESS.
  - On mem_ready=1:
    - Next edge: state goes to IDLE and mem_req=0.
    - wb_valid=1 with the latched dest/control.
    - LOAD: wb_data=mem_rdata and wb_write_en=1.
    - STORE: wb_data=latched address zero-extended and wb_write_en=0.
- Minimum LOAD latency: accept at T, mem_req at T+1, mem_ready at T+1, wb_valid at T+2.
- Back-to-back instructions:
  - The instruction presented on the cycle after completion is accepted from IDLE normally.
  - No bubble insertion beyond the stall.
- mem_ready while mem_req=0 is ignored.
- The mem_rdata sample is taken only on the mem_ready cycle.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - The mem_watchdog counter clears on entry to ACCESS and increments every ACCESS cycle.
  - If it reaches TIMEOUT_CYCLES with no mem_ready: stall=0 that cycle; next edge mem_req=0, state IDLE, wb_valid=1, wb_write_en=0, mem_error=1.
  - mem_error is sticky until reset.
  - mem_ready arriving in the same cycle as the timeout wins; it completes normally with no error.
- Not defined:
  - ACCESS waits indefinitely.
  - mem_error is tied 0.
  - No counter logic exists.

Decomposition:
- Shared package cpu_pkg holds:
  - Opcode constants (NOP through MOV, 4-bit).
  - DATA_W=16, REG_IDX_W=5, CTRL_W=5.
  - The memory_stage state enum {IDLE, ACCESS}.
- Sub-module mem_watchdog (timeout counter with clear/enable/expired), instantiated only under MEM_TIMEOUT_EN.

Test Plan:
- ADD: control=5'b00010, result_in=15, dest=2, we=1 -> next cycle wb_valid=1, wb_data=15, wb_dest=2, wb_write_en=1, stall never asserted.
- LOAD: control=5'b01100, result_in=16'h0008, memory ready after 3 cycles with rdata=16'h00AB -> stall high 4 cycles; mem_addr=8, mem_we=0; wb_data=16'h00AB, wb_write_en=1 one cycle after ready.
- STORE: result_in=16, store_data=31, ready immediate -> mem_we=1, mem_addr=16, mem_wdata=31 for one cycle; wb_write_en=0.
- LOAD with ready in ACCESS cycle 1, followed immediately by ADDI result 17 -> ADDI wb_valid one cycle after LOAD wb_valid; LOAD is not re-issued.
- Reset asserted during ACCESS, then mem_ready pulsed -> mem_req=0 after the edge; no wb_valid; state IDLE.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready never asserted -> mem_req drops after 4 ACCESS cycles; wb_valid=1 with wb_write_en=0; mem_error=1 and stays high until reset.
